cmov_regfile: RTL
=================

// Module: cmov_regfile
// PURPOSE
//   General-purpose register file for the single-cycle Mini RISC core. It consumes the cmov flag from
//   the move/conditional-move comparator and suppresses write-back on a failed CMOV. It also feeds
//   rs_data/rt_data back to that comparator and to the ALU, and counts suppressed CMOV writes.
// PARAMETERS
//   DATA_W     32   register width
//   NREGS      32   number of registers; R0 reads as zero
//   ADDR_W     5    register index width, must equal clog2(NREGS)
//   CNT_W      16   width of the suppressed-write counter
// PORTS
//   clk            in   1       core clock; all state updates on posedge
//   rst            in   1       synchronous, active-high reset
//   rs_addr        in   ADDR_W  read port A index
//   rt_addr        in   ADDR_W  read port B index
//   rs_data        out  DATA_W  read port A data (to comparator/ALU)
//   rt_data        out  DATA_W  read port B data
//   opcode         in   6       current instruction opcode
//   reg_write      in   1       write-back request from main control
//   wr_addr        in   ADDR_W  destination register index
//   wr_data        in   DATA_W  write-back value
//   cmov           in   1       comparator output: 1 = move permitted
//   wr_commit      out  1       1 when this cycle's write actually lands (combinational)
//   suppress_cnt   out  CNT_W   count of CMOV writes blocked by cmov=0
// BEHAVIOUR
//   - Move class: opcode 6'b110000 (MOVE) or 6'b110001 (CMOV).
//   - wr_commit = reg_write & (wr_addr != 0) & (~move_class | cmov) & ~rst.
//   - Writes: on posedge clk with wr_commit=1, regs[wr_addr] <= wr_data. Write latency is 1 cycle;
//     the value is visible on the read ports from the next cycle onward.
//   - Writes to R0 are discarded. R0 always reads 0.
//   - Reads: combinational, asynchronous to the clock. Index 0 returns 0.
//   - Reset: with rst=1 at posedge, all registers clear to 0 and suppress_cnt clears to 0. While rst=1:
//     rs_data = rt_data = 0 and wr_commit = 0. A write coincident with reset is dropped; reset wins.
//   - Counter: at a posedge where reg_write=1, opcode=CMOV, cmov=0 and rst=0, suppress_cnt increments.
//     It saturates at all-ones and does not wrap.
//   - MOVE with cmov=0 is not counted; MOVE is gated by cmov only, which the comparator drives to 1.
//   - Read and write to the same index in the same cycle: behaviour is set by REGFILE_BYPASS_EN.
//   - Reset deasserted mid-program: the register state restarts from all zeros; no partial state remains.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - when wr_commit=1 and a read index equals wr_addr (nonzero), that port returns wr_data in the same
//       cycle (write-through).
//   REGFILE_BYPASS_EN undefined:
//     - the read port returns the old stored value; the new value appears the next cycle.
//     - default build.
// STRUCTURE
//   - Shared package mini_risc_pkg holds OP_MOVE=6'b110000, OP_CMOV=6'b110001, REG_ADDR_W=5,
//     DATA_W=32. The comparator uses the same constants.
//   - One sub-module, cmov_wb_gate: combinational move-class decode plus wr_commit and suppress-event
//     generation.
//   - Storage array, read muxes (plus bypass) and the saturating counter stay in the top module.
// TESTING
//   1. rst=1 for 2 cycles after random writes -> all 32 reads = 0, suppress_cnt=0, wr_commit=0.
//   2. reg_write=1, opcode=ADD, wr_addr=5, wr_data=32'hDEADBEEF -> next cycle rs_addr=5 reads DEADBEEF.
//   3. opcode=CMOV, cmov=0, wr_addr=7, wr_data=1 over R7=32'h55 -> R7 stays 0x55, suppress_cnt 0->1.
//   4. opcode=CMOV, cmov=1, wr_addr=7, wr_data=32'hA5 -> R7=0xA5, wr_commit=1, counter unchanged.
//   5. Write 32'hFFFF_FFFF to R0 -> R0 reads 0; wr_commit=0.
//   6. Same-cycle write/read of R9 -> bypass build returns new value; default build returns old value.
//   7. Force 2^CNT_W+3 failed CMOVs (CNT_W=4 build) -> suppress_cnt holds 4'hF.

Source files
------------

// File: rtl/mini_risc_pkg.sv
// ----------------------------------------------------------------------------
// mini_risc_pkg
//   Constants shared by the Mini RISC register file and the move/conditional-
//   move comparator.
//   Contents:
//     OP_MOVE, OP_CMOV  move-class opcodes
//     REG_ADDR_W        register index width
//     DATA_W            datapath width
//     wb_class_e        write-back class of an opcode
//     wb_class()        opcode -> write-back class decode
// ----------------------------------------------------------------------------
package mini_risc_pkg;

    localparam logic [5:0] OP_MOVE    = 6'b110000;
    localparam logic [5:0] OP_CMOV    = 6'b110001;
    localparam int         REG_ADDR_W = 5;
    localparam int         DATA_W     = 32;

    typedef enum logic [1:0] {
        WB_NORMAL = 2'd0,
        WB_MOVE   = 2'd1,
        WB_CMOV   = 2'd2
    } wb_class_e;

    function automatic wb_class_e wb_class(input logic [5:0] op);
        wb_class_e c;
        c = WB_NORMAL;
        if (op == OP_MOVE) c = WB_MOVE;
        if (op == OP_CMOV) c = WB_CMOV;
        return c;
    endfunction

endpackage

// File: rtl/cmov_wb_gate.sv
// ----------------------------------------------------------------------------
// cmov_wb_gate
//   Combinational write-back gate: decodes the move class of the current
//   opcode, decides whether the write actually lands, and flags a CMOV write
//   that was blocked by the comparator.
//   Ports:
//     rst           in   synchronous reset (blocks all commits while high)
//     opcode        in   current instruction opcode
//     reg_write     in   write-back request from main control
//     wr_addr       in   destination register index
//     cmov          in   comparator result, 1 = move permitted
//     wr_commit     out  write lands this cycle
//     suppress_evt  out  a CMOV write was blocked this cycle
// ----------------------------------------------------------------------------
module cmov_wb_gate
    import mini_risc_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              cmov,
    output logic              wr_commit,
    output logic              suppress_evt
);

    wb_class_e cls;
    logic      move_class;

    always_comb begin
        cls          = wb_class(opcode);
        move_class   = (cls == WB_MOVE) || (cls == WB_CMOV);
        wr_commit    = reg_write && (wr_addr != '0) && (!move_class || cmov) && !rst;
        // Only CMOV counts; a blocked MOVE is a comparator fault, not a policy event.
        // The destination index plays no part in counting.
        suppress_evt = reg_write && (cls == WB_CMOV) && !cmov && !rst;
    end

endmodule

// File: rtl/cmov_regfile.sv
// ----------------------------------------------------------------------------
// cmov_regfile
//   General-purpose register file for the single-cycle Mini RISC core.
//   Two combinational read ports, one write port gated by the CMOV
//   comparator, and a saturating count of suppressed CMOV writes.
//   R0 reads as zero and ignores writes.
//   Configuration macro: REGFILE_BYPASS_EN
//     defined   : a read of the register being written returns wr_data in
//                 the same cycle (write-through)
//     undefined : the read returns the stored value; new data shows next cycle
//   Ports:
//     clk           in   core clock, posedge
//     rst           in   synchronous active-high reset
//     rs_addr       in   read port A index
//     rt_addr       in   read port B index
//     rs_data       out  read port A data
//     rt_data       out  read port B data
//     opcode        in   current instruction opcode
//     reg_write     in   write-back request
//     wr_addr       in   destination index
//     wr_data       in   write-back value
//     cmov          in   comparator result, 1 = move permitted
//     wr_commit     out  this cycle's write lands (combinational)
//     suppress_cnt  out  saturating count of blocked CMOV writes
// ----------------------------------------------------------------------------
module cmov_regfile #(
    parameter int DATA_W = mini_risc_pkg::DATA_W,
    parameter int NREGS  = 32,
    parameter int ADDR_W = mini_risc_pkg::REG_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic [5:0]        opcode,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cmov,
    output logic              wr_commit,
    output logic [CNT_W-1:0]  suppress_cnt
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              suppress_evt;

    cmov_wb_gate #(
        .ADDR_W (ADDR_W)
    ) u_wb_gate (
        .rst          (rst),
        .opcode       (opcode),
        .reg_write    (reg_write),
        .wr_addr      (wr_addr),
        .cmov         (cmov),
        .wr_commit    (wr_commit),
        .suppress_evt (suppress_evt)
    );

    // wr_commit is never set for index 0, so regs[0] is only ever cleared;
    // the read path forces zero regardless.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (wr_commit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            suppress_cnt <= '0;
        end else if (suppress_evt && (suppress_cnt != '1)) begin
            suppress_cnt <= suppress_cnt + 1'b1;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        v = regs[addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_commit && (addr == wr_addr)) v = wr_data;
`endif
        if (rst || (addr == '0)) v = '0;
        return v;
    endfunction

    always_comb begin
        rs_data = read_port(rs_addr);
        rt_data = read_port(rt_addr);
    end

endmodule
